// File: rtl/debounce_scan_ctrl.sv
// Multi-channel switch debouncer with a shared prescaler tick.
// Each channel runs a stable-count debounce. Debounced flips are arbitrated
// (fixed priority, lowest index first) into a small event FIFO.
// Optional feature macro: DB_EV_RELEASE_EN. When defined, releases (1->0)
// also raise events. When undefined, only presses (0->1) raise events.
module debounce_scan_ctrl #(
  parameter int unsigned NCH          = 4,
  parameter int unsigned TICK_W       = 19,
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] sw,
  output logic [NCH-1:0] db,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [3:0]     ev_code,
  output logic           ovf,
  input  logic           ovf_clr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [TICK_W-1:0] q_q;
  logic              tick;
  logic [2:0]        cnt_q [NCH];
  logic [2:0]        cnt_d [NCH];
  logic [NCH-1:0]    db_q, db_d;
  logic [NCH-1:0]    flip, ev_raise;
  logic [NCH-1:0]    pend_q, pend_d, plv_q, plv_d;
  logic              ovf_q, ovf_d, ovf_set;
  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full, empty, push, pop, pend_any, sel_lv;
  logic [2:0]        sel;

  assign tick = (q_q == '0);

  // Per-channel stable-count debounce; a flip fires on the last required tick.
  always_comb begin
    db_d = db_q;
    flip = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sw[i] == db_q[i]) begin
        cnt_d[i] = 3'd0;
      end else if (tick) begin
        if (cnt_q[i] == 3'(STABLE_TICKS - 1)) begin
          db_d[i]  = sw[i];
          cnt_d[i] = 3'd0;
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
  end

`ifdef DB_EV_RELEASE_EN
  assign ev_raise = flip;
`else
  // Releases still update db but never reach the event path.
  assign ev_raise = flip & sw;
`endif

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = ev_ready & ~empty;
  assign push  = pend_any & ~full;

  // Fixed-priority arbiter plus pending/overflow bookkeeping.
  always_comb begin
    pend_any = 1'b0;
    sel      = 3'd0;
    sel_lv   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pend_q[i] && !pend_any) begin
        pend_any = 1'b1;
        sel      = 3'(i);
        sel_lv   = plv_q[i];
      end
    end
    pend_d  = pend_q;
    plv_d   = plv_q;
    ovf_set = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (push && sel == 3'(i)) pend_d[i] = 1'b0;
      // A flip on the servicing edge simply re-arms pend; otherwise it overwrites.
      if (ev_raise[i]) begin
        if (pend_q[i] && !(push && sel == 3'(i))) ovf_set = 1'b1;
        pend_d[i] = 1'b1;
        plv_d[i]  = sw[i];
      end
    end
    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // State registers for prescaler, channels, pending and overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      db_q   <= '0;
      pend_q <= '0;
      plv_q  <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= 3'd0;
    end else begin
      q_q    <= q_q + TICK_W'(1);
      db_q   <= db_d;
      pend_q <= pend_d;
      plv_q  <= plv_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Event FIFO: circular buffer with registered pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {sel_lv, sel};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign db       = db_q;
  assign ovf      = ovf_q;
  assign ev_valid = ~empty;
  assign ev_code  = empty ? 4'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with a 16-clock tick (TICK_W=4).
// Expected values are hand-derived from the edge count since reset release.
module tb_debounce_scan_ctrl;

  localparam int TICKS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] db;
  logic       ev_valid, ev_ready, ovf, ovf_clr;
  logic [3:0] ev_code;

  int checks = 0;
  int errors = 0;
  int ec     = 0;

  debounce_scan_ctrl #(
    .NCH          (4),
    .TICK_W       (4),
    .STABLE_TICKS (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db       (db),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the edge just taken was a prescaler tick.
  task automatic step_to_tick();
    do step(); while (((ec - 1) % TICKS) != 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    sw       = 4'b0000;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    #12;
    check("rst_db", db, 0);
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ec    = 0;

    // Glitch: two ticks of disagreement then back to agreement.
    sw = 4'b0001;
    steps(20);
    sw = 4'b0000;
    step_to_tick();
    step_to_tick();
    check("glitch_db", db, 0);
    check("glitch_valid", ev_valid, 0);
    check("glitch_cnt", dut.cnt_q[0], 0);

    // Single press on ch0.
    sw = 4'b0001;
    step_to_tick();
    step_to_tick();
    check("press_db_early", db, 0);
    step_to_tick();
    check("press_db", db, 4'b0001);
    check("press_valid_e", ev_valid, 0);
    step();
    check("press_valid", ev_valid, 1);
    check("press_code", ev_code, 4'b1000);
    ev_ready = 1'b1;
    step();
    check("press_pop", ev_valid, 0);

    // Release ch0.
    sw = 4'b0000;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    check("rel0_db", db, 0);
    step();
`ifdef DB_EV_RELEASE_EN
    check("rel0_valid", ev_valid, 1);
    check("rel0_code", ev_code, 4'b0000);
    step();
`endif
    check("rel0_empty", ev_valid, 0);

    // All four pressed together; ev_ready stays 1.
    sw = 4'b1111;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    check("all_db", db, 4'b1111);
    step();
    check("all_c0", ev_code, 4'h8);
    step();
    check("all_c1", ev_code, 4'h9);
    step();
    check("all_c2", ev_code, 4'hA);
    step();
    check("all_c3", ev_code, 4'hB);
    step();
    check("all_empty", ev_valid, 0);
    check("all_ovf", ovf, 0);

`ifdef DB_EV_RELEASE_EN
    // Release all and drain the four release events.
    sw = 4'b0000;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    steps(6);
    check("drain_rel", ev_valid, 0);
    // Fill the FIFO with presses, then release/re-press ch0 while full.
    ev_ready = 1'b0;
    sw = 4'b1111;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    steps(4);
    check("full_head", ev_code, 4'h8);
    sw = 4'b1110;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    check("full_rel_db", db, 4'b1110);
    check("full_rel_ovf", ovf, 0);
    sw = 4'b1111;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    check("full_rep_db", db, 4'b1111);
    check("full_rep_ovf", ovf, 1);
    ev_ready = 1'b1;
    step();
    check("drn_1", ev_code, 4'h9);
    step();
    check("drn_2", ev_code, 4'hA);
    step();
    check("drn_3", ev_code, 4'hB);
    step();
    check("drn_ch0", ev_code, 4'h8);
    step();
    check("drn_empty", ev_valid, 0);
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
`else
    // Release all silently, then press/release ch2: one event only.
    sw = 4'b0000;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    check("relall_db", db, 0);
    step();
    check("relall_valid", ev_valid, 0);
    sw = 4'b0100;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    check("ch2_db", db, 4'b0100);
    step();
    check("ch2_code", ev_code, 4'b1010);
    step();
    check("ch2_pop", ev_valid, 0);
    sw = 4'b0000;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    check("ch2_rel_db", db, 0);
    step();
    check("ch2_rel_valid", ev_valid, 0);
    check("ch2_ovf", ovf, 0);
`endif

    // Reset mid-operation with two events queued and ch1 counting.
    reset = 1'b0;
    step();
    reset    = 1'b1;
    ec       = 0;
    ev_ready = 1'b0;
    sw       = 4'b1100;
    step_to_tick();
    step_to_tick();
    step_to_tick();
    steps(2);
    check("q2_head", ev_code, 4'hA);
    sw = 4'b1110;
    step_to_tick();
    step_to_tick();
    check("q2_cnt1", dut.cnt_q[1], 2);
    reset = 1'b0;
    #1;
    check("mid_valid", ev_valid, 0);
    check("mid_db", db, 0);
    check("mid_ovf", ovf, 0);
    check("mid_code", ev_code, 0);
    step();
    reset = 1'b1;
    ec    = 0;
    steps(32);
    check("resume_early", db, 0);
    step();
    check("resume_db", db, 4'b1110);
    step();
    check("resume_c1", ev_code, 4'h9);
    ev_ready = 1'b1;
    step();
    check("resume_c2", ev_code, 4'hA);
    step();
    check("resume_c3", ev_code, 4'hB);
    step();
    check("resume_empty", ev_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
